// File: rtl/key_dir_arbiter.sv
// rtl/key_dir_arbiter.sv - key press edge detect, direction arbitration, move FIFO and run/pause state
module key_dir_arbiter #(
  parameter int         DEPTH    = 2,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic                     key_mid,
  input  logic                     tick,
  output logic [1:0]               dir,
  output logic                     dir_valid,
  output logic                     paused,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      prev_q;
  logic [1:0]      dir_q, dir_d;
  logic            dir_valid_q, dir_valid_d;
  logic [1:0]      fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [4:0]      level;
  logic [4:0]      press;
  logic            mid_press;
  logic            cand_valid;
  logic [1:0]      cand;
  logic [PW-1:0]   tail_idx;
  logic [1:0]      ref_dir;
  logic            full;
  logic            accept;
  logic            do_pop;
  logic            do_push;
  logic            flush;

  // Bit order: up, down, left, right, mid; the order also sets arbitration priority.
  assign level     = {key_up, key_down, key_left, key_right, key_mid};
  assign press     = level & ~prev_q;
  assign mid_press = press[0];

  always_comb begin
    cand_valid = 1'b1;
    cand       = 2'd0;
    if (press[4])      cand = 2'd0;
    else if (press[3]) cand = 2'd1;
    else if (press[2]) cand = 2'd2;
    else if (press[1]) cand = 2'd3;
    else               cand_valid = 1'b0;
  end

  // A new move is judged against the last queued move, or the live heading when empty.
  assign tail_idx = wr_ptr_q - 1'b1;
  assign ref_dir  = (count_q != '0) ? fifo_q[tail_idx] : dir_q;
  assign full     = (count_q == CW'(DEPTH));

  assign accept  = (state_q == ST_RUN) && !mid_press && cand_valid && (cand[1] != ref_dir[1]);
  assign do_pop  = (state_q == ST_RUN) && tick && (count_q != '0);
  assign do_push = accept && (!full || do_pop);
  assign flush   = (state_q == ST_RUN) && mid_press;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (mid_press) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end

    if (do_pop) begin
      dir_d       = fifo_q[rd_ptr_q];
      dir_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end

    // Pausing discards any queued moves so a resume starts from a clean slate.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PAUSE;
      prev_q      <= '1;
      dir_q       <= INIT_DIR;
      dir_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      prev_q      <= level;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (do_push && !flush) begin
        fifo_q[wr_ptr_q] <= cand;
      end
    end
  end

  assign dir       = dir_q;
  assign dir_valid = dir_valid_q;
  assign paused    = (state_q == ST_PAUSE);
  assign q_count   = count_q;

endmodule

// File: tb/tb_key_dir_arbiter.sv
// tb/tb_key_dir_arbiter.sv - directed vector bench for key_dir_arbiter
module tb_key_dir_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_up, key_down, key_left, key_right, key_mid;
  logic       tick;
  logic [1:0] dir;
  logic       dir_valid;
  logic       paused;
  logic [1:0] q_count;

  int passed = 0;
  int total  = 0;

  key_dir_arbiter #(.DEPTH(2), .INIT_DIR(2'd3)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .key_mid   (key_mid),
    .tick      (tick),
    .dir       (dir),
    .dir_valid (dir_valid),
    .paused    (paused),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  // keys bit order: up, down, left, right, mid
  typedef struct {
    string      name;
    logic [4:0] keys;
    logic       tk;
    logic [1:0] e_dir;
    logic       e_valid;
    logic       e_paused;
    logic [1:0] e_count;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_UP   = 5'b10000;
  localparam logic [4:0] K_DN   = 5'b01000;
  localparam logic [4:0] K_LF   = 5'b00100;
  localparam logic [4:0] K_RT   = 5'b00010;
  localparam logic [4:0] K_MID  = 5'b00001;

  function automatic void add(string n, logic [4:0] k, logic t, logic [1:0] d,
                              logic v, logic p, logic [1:0] c);
    vec_t e;
    e.name = n; e.keys = k; e.tk = t;
    e.e_dir = d; e.e_valid = v; e.e_paused = p; e.e_count = c;
    vecs.push_back(e);
  endfunction

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic drive(logic [4:0] k, logic t);
    @(negedge clk);
    {key_up, key_down, key_left, key_right, key_mid} = k;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string n, logic [1:0] d, logic v, logic p, logic [1:0] c);
    chk({n, ".dir"},       8'(dir),       8'(d));
    chk({n, ".dir_valid"}, 8'(dir_valid), 8'(v));
    chk({n, ".paused"},    8'(paused),    8'(p));
    chk({n, ".q_count"},   8'(q_count),   8'(c));
  endtask

  initial begin
    //   name            keys          tick dir v  p  cnt
    add("hold_right",    K_RT,         0,   3,  0, 1, 0);
    add("tick_paused",   K_NONE,       1,   3,  0, 1, 0);
    add("mid_run",       K_MID,        0,   3,  0, 0, 0);
    add("rel0",          K_NONE,       0,   3,  0, 0, 0);
    add("push_up",       K_UP,         0,   3,  0, 0, 1);
    add("tick_up",       K_NONE,       1,   0,  1, 0, 0);
    add("pulse_end",     K_NONE,       0,   0,  0, 0, 0);
    add("down_rev",      K_DN,         0,   0,  0, 0, 0);
    add("rel1",          K_NONE,       0,   0,  0, 0, 0);
    add("up_same",       K_UP,         0,   0,  0, 0, 0);
    add("rel2",          K_NONE,       0,   0,  0, 0, 0);
    add("push_left",     K_LF,         0,   0,  0, 0, 1);
    add("rel3",          K_NONE,       0,   0,  0, 0, 1);
    add("tick_left",     K_NONE,       1,   2,  1, 0, 0);
    add("push_down",     K_DN,         0,   2,  0, 0, 1);
    add("tick_down",     K_NONE,       1,   1,  1, 0, 0);
    add("push_right",    K_RT,         0,   1,  0, 0, 1);
    add("tick_right",    K_NONE,       1,   3,  1, 0, 0);
    add("t4_up",         K_UP,         0,   3,  0, 0, 1);
    add("t4_rel_a",      K_NONE,       0,   3,  0, 0, 1);
    add("t4_left_tail",  K_LF,         0,   3,  0, 0, 2);
    add("t4_rel_b",      K_NONE,       0,   3,  0, 0, 2);
    add("t4_down_full",  K_DN,         0,   3,  0, 0, 2);
    add("t4_rel_c",      K_NONE,       0,   3,  0, 0, 2);
    add("t4_tick1",      K_NONE,       1,   0,  1, 0, 1);
    add("t4_tick2",      K_NONE,       1,   2,  1, 0, 0);
    add("t5_down",       K_DN,         0,   2,  0, 0, 1);
    add("t5_tick_a",     K_NONE,       1,   1,  1, 0, 0);
    add("t5_right",      K_RT,         0,   1,  0, 0, 1);
    add("t5_tick_b",     K_NONE,       1,   3,  1, 0, 0);
    add("t5_up_left",    K_UP | K_LF,  0,   3,  0, 0, 1);
    add("t5_rel_a",      K_NONE,       0,   3,  0, 0, 1);
    add("t5_left",       K_LF,         0,   3,  0, 0, 2);
    add("t5_rel_b",      K_NONE,       0,   3,  0, 0, 2);
    add("t5_full_tkpsh", K_DN,         1,   0,  1, 0, 2);
    add("t5_rel_c",      K_NONE,       0,   0,  0, 0, 2);
    add("t5_tick_lf",    K_NONE,       1,   2,  1, 0, 1);
    add("t5_tick_dn",    K_NONE,       1,   1,  1, 0, 0);
    add("t5_rel_d",      K_NONE,       0,   1,  0, 0, 0);
    add("t6_left",       K_LF,         0,   1,  0, 0, 1);
    add("t6_rel_a",      K_NONE,       0,   1,  0, 0, 1);
    add("t6_pause",      K_MID,        0,   1,  0, 1, 0);
    add("t6_tick_ign",   K_NONE,       1,   1,  0, 1, 0);
    add("t6_up_drop",    K_UP,         0,   1,  0, 1, 0);
    add("t6_tick_ign2",  K_NONE,       1,   1,  0, 1, 0);
    add("t6_resume",     K_MID,        0,   1,  0, 0, 0);
    add("t6_rel_b",      K_NONE,       0,   1,  0, 0, 0);
    add("mid_plus_left", K_MID | K_LF, 0,   1,  0, 1, 0);
    add("rel_ml",        K_NONE,       0,   1,  0, 1, 0);
    add("resume2",       K_MID,        0,   1,  0, 0, 0);
    add("rel_r2",        K_NONE,       0,   1,  0, 0, 0);
    add("empty_tk_push", K_LF,         1,   1,  0, 0, 1);
    add("rel_etp",       K_NONE,       0,   1,  0, 0, 1);

    rst = 1'b1;
    {key_up, key_down, key_left, key_right, key_mid} = K_RT;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 2'd3, 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].keys, vecs[i].tk);
      check_all(vecs[i].name, vecs[i].e_dir, vecs[i].e_valid, vecs[i].e_paused, vecs[i].e_count);
    end

    // Reset wins over a same-cycle tick that would otherwise pop the queued move.
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_tick", 2'd3, 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst", 2'd3, 1'b0, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
